// File: rtl/bsg_gateway_tag_master_if.sv
// Bundles the tag master's control inputs, client payload bus and serial
// tag outputs. The master modport belongs to the tag master; the slave
// modport belongs to whatever drives the payloads and observes the ring.
interface bsg_gateway_tag_master_if #(
  parameter int els_p        = 2,
  parameter int data_width_p = 8
);
  logic                            start_i;
  logic                            control_i;
  logic [els_p*data_width_p-1:0]   data_i;
  logic                            tag_tdi_o;
  logic                            tag_tms_o;
  logic                            busy_o;
  logic                            done_o;

  modport master (
    input  start_i, control_i, data_i,
    output tag_tdi_o, tag_tms_o, busy_o, done_o
  );

  modport slave (
    output start_i, control_i, data_i,
    input  tag_tdi_o, tag_tms_o, busy_o, done_o
  );
endinterface

// File: rtl/bsg_gateway_tag_master.sv
// Tag ring master: resets the tag ring, programs every client once in index
// order, then watches the client payloads and resends any client whose live
// payload differs from what was last sent (its shadow), lowest index first.
// Frame on tag_tdi_o: start 1, client id MSB-first, data_not_reset 1,
// payload LSB-first. All outputs come straight from flops.
module bsg_gateway_tag_master #(
  parameter int els_p          = 2,
  parameter int data_width_p   = 8,
  parameter int reset_cycles_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  bsg_gateway_tag_master_if.master bus
);

  localparam int id_width_lp  = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int frame_len_lp = 2 + id_width_lp + data_width_p;
  localparam int cnt_max_lp   = (reset_cycles_p > frame_len_lp) ? reset_cycles_p : frame_len_lp;
  localparam int cnt_w_lp     = $clog2(cnt_max_lp + 1);

  localparam logic [cnt_w_lp-1:0]    rst_last_lp   = cnt_w_lp'(reset_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0]    frame_last_lp = cnt_w_lp'(frame_len_lp - 1);
  localparam logic [id_width_lp-1:0] last_id_lp    = id_width_lp'(els_p - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RING_RESET = 3'd1,
    SCAN       = 3'd2,
    SEND       = 3'd3,
    MONITOR    = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [cnt_w_lp-1:0]       cnt_q, cnt_d;
  logic [id_width_lp-1:0]    sel_q, sel_d;
  logic [data_width_p-1:0]   snap_q, snap_d;
  logic [frame_len_lp-1:0]   sh_q, sh_d;
  logic [data_width_p-1:0]   shadow_q [els_p];
  logic                      shadow_we;
  logic                      tdi_q, tdi_d;
  logic                      tms_q, tms_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [els_p-1:0]          diff;
  logic                      pend;
  logic [id_width_lp-1:0]    low_idx;
  logic [data_width_p-1:0]   sel_data;
  logic [data_width_p-1:0]   low_data;
  logic [frame_len_lp-1:0]   frame_w;

  // Serial frame image, first transmitted bit in the MSB.
  function automatic logic [frame_len_lp-1:0] build_frame(
    input logic [id_width_lp-1:0]  id,
    input logic [data_width_p-1:0] payload
  );
    logic [data_width_p-1:0] rev;
    for (int b = 0; b < data_width_p; b++) rev[b] = payload[data_width_p-1-b];
    return {1'b1, id, 1'b1, rev};
  endfunction

  // Compare live payloads with shadows; find the lowest differing client.
  always_comb begin
    diff     = '0;
    low_idx  = '0;
    sel_data = '0;
    low_data = '0;
    for (int k = 0; k < els_p; k++)
      diff[k] = (bus.data_i[k*data_width_p +: data_width_p] != shadow_q[k]);
    for (int k = els_p - 1; k >= 0; k--)
      if (diff[k]) low_idx = id_width_lp'(k);
    for (int k = 0; k < els_p; k++) begin
      if (sel_q == id_width_lp'(k))   sel_data = bus.data_i[k*data_width_p +: data_width_p];
      if (low_idx == id_width_lp'(k)) low_data = bus.data_i[k*data_width_p +: data_width_p];
    end
  end

  assign pend = bus.control_i && (|diff);

  // Next state plus the values the output flops take with it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    snap_d    = snap_q;
    sh_d      = sh_q;
    done_d    = done_q;
    shadow_we = 1'b0;
    frame_w   = '0;
    tdi_d     = 1'b0;
    tms_d     = 1'b0;
    busy_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = RING_RESET;
          cnt_d   = '0;
          tms_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RING_RESET: begin
        if (cnt_q == rst_last_lp) begin
          state_d = SCAN;
          cnt_d   = '0;
          sel_d   = '0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          tms_d  = 1'b1;
          busy_d = 1'b1;
        end
      end
      SCAN: begin
        // Initial pass sends every client in order; afterwards only
        // differing clients are sent while control_i allows it.
        if (!done_q || pend) begin
          state_d = SEND;
          cnt_d   = '0;
          busy_d  = 1'b1;
          if (done_q) begin
            sel_d  = low_idx;
            snap_d = low_data;
          end else begin
            snap_d = sel_data;
          end
          frame_w = build_frame(sel_d, snap_d);
          tdi_d   = frame_w[frame_len_lp-1];
          sh_d    = {frame_w[frame_len_lp-2:0], 1'b0};
        end else begin
          state_d = MONITOR;
        end
      end
      SEND: begin
        if (cnt_q == frame_last_lp) begin
          shadow_we = 1'b1;
          cnt_d     = '0;
          if (!done_q && sel_q == last_id_lp) begin
            done_d  = 1'b1;
            state_d = MONITOR;
          end else begin
            state_d = SCAN;
            if (!done_q) sel_d = sel_q + 1'b1;
          end
        end else begin
          cnt_d  = cnt_q + 1'b1;
          tdi_d  = sh_q[frame_len_lp-1];
          sh_d   = {sh_q[frame_len_lp-2:0], 1'b0};
          busy_d = 1'b1;
        end
      end
      MONITOR: begin
        if (pend) state_d = SCAN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, shadows and registered outputs; reset clears all at once.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      tdi_q   <= 1'b0;
      tms_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < els_p; k++) shadow_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      tdi_q   <= tdi_d;
      tms_q   <= tms_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int k = 0; k < els_p; k++)
        if (shadow_we && sel_q == id_width_lp'(k)) shadow_q[k] <= snap_q;
    end
  end

  // Payload snapshot and frame shifter; only meaningful inside SEND.
  always_ff @(posedge clk_i) begin
    snap_q <= snap_d;
    sh_q   <= sh_d;
  end

  assign bus.tag_tdi_o = tdi_q;
  assign bus.tag_tms_o = tms_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;

endmodule
